// File: rtl/cache_arbiter.sv
// Alternating-priority arbiter that serializes I-cache reads and D-cache
// reads/write-backs onto one shared cacheline memory port.
module cache_arbiter #(
  parameter int S_ADDR = 32,
  parameter int S_LINE = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [S_ADDR-1:0] i_pmem_address,
  output logic [S_LINE-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [S_ADDR-1:0] d_pmem_address,
  input  logic [S_LINE-1:0] d_pmem_wdata,
  output logic [S_LINE-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [S_ADDR-1:0] mem_address,
  output logic [S_LINE-1:0] mem_wdata,
  input  logic [S_LINE-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic [1:0]        state_o
);

  // Handshake: a client holds its request level until its one-cycle resp
  // pulse; the memory port request stays asserted through the mem_resp cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic              op_write_q, op_write_d;
  logic [S_ADDR-1:0] addr_q, addr_d;
  logic [S_LINE-1:0] wdata_q, wdata_d;

  logic i_req, d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_write_q   <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_write_q   <= op_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_write_d   = op_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    case (state_q)
      IDLE: begin
        // On a tie the client that did not win last time is served.
        if (i_req && (!d_req || last_grant_q)) begin
          addr_d       = i_pmem_address;
          last_grant_d = 1'b0;
          state_d      = I_BUSY;
        end else if (d_req) begin
          addr_d       = d_pmem_address;
          wdata_d      = d_pmem_wdata;
          op_write_d   = d_pmem_write;
          last_grant_d = 1'b1;
          state_d      = D_BUSY;
        end
      end
      I_BUSY: begin
        mem_read = 1'b1;
        if (mem_resp && !rst) begin
          i_pmem_resp = 1'b1;
          state_d     = DONE;
        end
      end
      D_BUSY: begin
        mem_read  = !op_write_q;
        mem_write = op_write_q;
        if (mem_resp && !rst) begin
          d_pmem_resp = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_address  = addr_q;
  assign mem_wdata    = wdata_q;
  assign i_pmem_rdata = i_pmem_resp ? mem_rdata : '0;
  assign d_pmem_rdata = d_pmem_resp ? mem_rdata : '0;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: a bench-side arbitration model
// predicts grant order; a memory model returns lines checked at the clients.
module tb_cache_arbiter;

  localparam int W_ADDR = 32;
  localparam int W_LINE = 256;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [W_ADDR-1:0] i_pmem_address;
  logic [W_LINE-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [W_ADDR-1:0] d_pmem_address;
  logic [W_LINE-1:0] d_pmem_wdata;
  logic [W_LINE-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              mem_read;
  logic              mem_write;
  logic [W_ADDR-1:0] mem_address;
  logic [W_LINE-1:0] mem_wdata;
  logic [W_LINE-1:0] mem_rdata;
  logic              mem_resp;
  logic [1:0]        state_o;

  cache_arbiter #(.S_ADDR(W_ADDR), .S_LINE(W_LINE)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  // exp_q entry: {client (0 = I, 1 = D), write, address}
  logic [33:0]       exp_q[$];
  logic [W_LINE-1:0] exp_data_q[$];
  logic [W_LINE-1:0] exp_wdata_q[$];
  logic [W_LINE-1:0] mem_line_q[$];
  logic              model_last;
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic check_eq(input string tag, input logic [W_LINE-1:0] got,
                          input logic [W_LINE-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W_LINE-1:0] rand_line();
    logic [W_LINE-1:0] l;
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic logic [W_ADDR-1:0] rand_addr();
    logic [W_ADDR-1:0] a;
    a = $urandom;
    a[4:0] = 5'd0;
    return a;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_i(input logic [W_ADDR-1:0] addr, input logic [W_LINE-1:0] line);
    exp_q.push_back({1'b0, 1'b0, addr});
    exp_data_q.push_back(line);
    mem_line_q.push_back(line);
  endtask

  task automatic push_d(input logic wr, input logic [W_ADDR-1:0] addr,
                        input logic [W_LINE-1:0] wdata, input logic [W_LINE-1:0] line);
    exp_q.push_back({1'b1, wr, addr});
    exp_data_q.push_back(line);
    mem_line_q.push_back(line);
    if (wr) exp_wdata_q.push_back(wdata);
  endtask

  task automatic drive_i(input logic [W_ADDR-1:0] addr);
    i_pmem_read    = 1'b1;
    i_pmem_address = addr;
  endtask

  task automatic drive_d(input logic wr, input logic both_hi, input logic [W_ADDR-1:0] addr,
                         input logic [W_LINE-1:0] wdata);
    d_pmem_write   = wr;
    d_pmem_read    = !wr || both_hi;
    d_pmem_address = addr;
    d_pmem_wdata   = wdata;
  endtask

  task automatic req_i(input logic [W_ADDR-1:0] addr, input logic [W_LINE-1:0] line);
    drive_i(addr);
    push_i(addr, line);
  endtask

  task automatic req_d(input logic wr, input logic both_hi, input logic [W_ADDR-1:0] addr,
                       input logic [W_LINE-1:0] wdata, input logic [W_LINE-1:0] line);
    drive_d(wr, both_hi, addr, wdata);
    push_d(wr, addr, wdata, line);
  endtask

  // Both clients request in the same cycle; the model decides who wins.
  task automatic req_both(input logic [W_ADDR-1:0] ia, input logic dwr,
                          input logic [W_ADDR-1:0] da, input logic [W_LINE-1:0] dwd);
    logic [W_LINE-1:0] il, dl;
    il = rand_line();
    dl = rand_line();
    drive_i(ia);
    drive_d(dwr, 1'b0, da, dwd);
    if (model_last) begin
      push_i(ia, il);
      push_d(dwr, da, dwd, dl);
    end else begin
      push_d(dwr, da, dwd, dl);
      push_i(ia, il);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  // Memory model + response checker for the next expected grant.
  task automatic serve(input int lat, input int exp_wait, input bit perturb, input bit reissue);
    logic [33:0]       e;
    logic [W_LINE-1:0] exp_line;
    logic [W_LINE-1:0] wd;
    int                waited;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(mem_read || mem_write) && waited < 40);
    check_eq("grant_wait", waited, exp_wait);
    if (!(mem_read || mem_write) || exp_q.size() == 0) begin
      check_eq("grant_seen", {mem_read, mem_write, 1'b0}, 3'b100);
      return;
    end
    e          = exp_q.pop_front();
    exp_line   = exp_data_q.pop_front();
    model_last = e[33];
    check_eq("mem_address", mem_address, e[31:0]);
    check_eq("mem_write", mem_write, e[32]);
    check_eq("mem_read", mem_read, !e[32]);
    if (e[32]) begin
      wd = exp_wdata_q.pop_front();
      check_eq("mem_wdata", mem_wdata, wd);
    end
    if (perturb) begin
      d_pmem_address = ~e[31:0];
      d_pmem_wdata   = rand_line();
    end
    repeat (lat) begin
      @(negedge clk);
      check_eq("addr_hold", mem_address, e[31:0]);
      check_eq("req_hold", {mem_read, mem_write}, {!e[32], e[32]});
      check_eq("early_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    end
    mem_rdata = mem_line_q.pop_front();
    mem_resp  = 1'b1;
    #1;
    check_eq("i_resp", i_pmem_resp, !e[33]);
    check_eq("d_resp", d_pmem_resp, e[33]);
    if (!e[33]) check_eq("i_rdata", i_pmem_rdata, exp_line);
    else if (!e[32]) check_eq("d_rdata", d_pmem_rdata, exp_line);
    // A stray mem_resp held into DONE must not produce a second pulse.
    @(negedge clk);
    #1;
    check_eq("done_state", state_o, ST_DONE);
    check_eq("done_mem_req", {mem_read, mem_write}, 2'b00);
    check_eq("done_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    if (!e[33]) begin
      i_pmem_read = 1'b0;
      if (reissue) req_i(rand_addr(), rand_line());
    end else begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
      if (reissue) req_d(1'($urandom_range(0, 1)), 1'b0, rand_addr(), rand_line(), rand_line());
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W_LINE-1:0] a5_line, wd_line;
    int                waited;
    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    mem_rdata = '0; mem_resp = 1'b0;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check_eq("rst_state", state_o, ST_IDLE);
    check_eq("rst_mem_req", {mem_read, mem_write}, 2'b00);
    check_eq("rst_mem_address", mem_address, '0);
    check_eq("rst_mem_wdata", mem_wdata, '0);
    check_eq("rst_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    check_eq("rst_i_rdata", i_pmem_rdata, '0);
    check_eq("rst_d_rdata", d_pmem_rdata, '0);

    // I read alone
    a5_line = {32{8'hA5}};
    req_i(32'h0000_0060, a5_line);
    serve(3, 1, 1'b0, 1'b0);

    // D write-back with read also high: write must win
    wd_line = {8{32'h1234_5678}};
    @(negedge clk);
    req_d(1'b1, 1'b1, 32'h1000_0020, wd_line, rand_line());
    serve(2, 1, 1'b0, 1'b0);

    // Tie right after reset: I first, then D
    do_reset();
    req_both(32'h0000_0100, 1'b0, 32'h2000_0040, '0);
    serve(1, 1, 1'b0, 1'b0);
    serve(2, 2, 1'b0, 1'b0);
    // I alone, then a tie: D wins now
    @(negedge clk);
    req_i(32'h0000_0200, rand_line());
    serve(1, 1, 1'b0, 1'b0);
    @(negedge clk);
    req_both(32'h0000_0300, 1'b1, 32'h3000_0060, rand_line());
    serve(2, 1, 1'b0, 1'b0);
    serve(1, 2, 1'b0, 1'b0);

    // Continuous requests from both: 8 alternating transactions
    @(negedge clk);
    req_both(rand_addr(), 1'b0, rand_addr(), rand_line());
    for (int k = 0; k < 6; k++) serve($urandom_range(0, 4), (k == 0) ? 1 : 2, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) serve($urandom_range(0, 4), 2, 1'b0, 1'b0);

    // Spurious mem_resp while idle, then D read whose inputs change after grant
    @(negedge clk);
    mem_rdata = rand_line();
    mem_resp  = 1'b1;
    #1;
    check_eq("idle_state", state_o, ST_IDLE);
    check_eq("idle_stray_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    @(negedge clk);
    mem_resp = 1'b0;
    req_d(1'b0, 1'b0, 32'h4000_00A0, '0, rand_line());
    serve(3, 1, 1'b1, 1'b0);

    // Reset while D write is in flight
    @(negedge clk);
    req_d(1'b1, 1'b0, 32'h5000_0020, rand_line(), rand_line());
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!mem_write && waited < 40);
    check_eq("abort_grant", mem_write, 1'b1);
    rst = 1'b1;
    d_pmem_write = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_state", state_o, ST_IDLE);
    check_eq("abort_mem_req", {mem_read, mem_write}, 2'b00);
    mem_resp = 1'b1;
    #1;
    check_eq("abort_resp", {i_pmem_resp, d_pmem_resp}, 2'b00);
    exp_q.delete(); exp_data_q.delete(); exp_wdata_q.delete(); mem_line_q.delete();
    model_last = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    req_i(32'h0000_0780, rand_line());
    serve(2, 1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_eq("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
